// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer. Entries sit in a circular array. A tag is the entry index + 1.
// Entries take CDB writebacks. Operand queries are combinational. A mispredict flushes the whole buffer.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena_from_dsp,
  input  logic [4:0]          rd_from_dsp,
  input  logic [31:0]         pc_from_dsp,
  output logic [ROB_ID_W-1:0] Q_to_dsp,
  output logic                full_to_dsp,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_Q,
  input  logic [31:0]         cdb_V,
  input  logic                cdb_mispredict,
  input  logic [31:0]         cdb_target_pc,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  output logic                ready1_to_dsp,
  output logic                ready2_to_dsp,
  output logic [31:0]         V1_to_dsp,
  output logic [31:0]         V2_to_dsp,
  output logic                commit_flag_to_rf,
  output logic [4:0]          rd_to_rf,
  output logic [ROB_ID_W-1:0] Q_to_rf,
  output logic [31:0]         V_to_rf,
  output logic                rollback_flag,
  output logic [31:0]         pc_to_if
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        mp;
    logic [4:0]  rd;
    logic [31:0] v;
    logic [31:0] tpc;
  } entry_t;

  entry_t [ROB_SIZE-1:0] ent_q, ent_d;
  logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d, wb_idx;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  commit_flag_q, commit_flag_d, rollback_q, rollback_d;
  logic [4:0]            rd_rf_q, rd_rf_d;
  logic [ROB_ID_W-1:0]   q_rf_q, q_rf_d;
  logic [31:0]           v_rf_q, v_rf_d, pc_if_q, pc_if_d;
  logic                  alloc, wb, commit;

  // The pc travels with the instruction but the buffer never needs it.
  logic unused_pc;
  assign unused_pc = ^pc_from_dsp;

  function automatic logic tag_ok(input logic [ROB_ID_W-1:0] t);
    return (t != '0) && (int'(t) <= ROB_SIZE);
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [ROB_ID_W-1:0] t);
    return IDX_W'(t - ROB_ID_W'(1));
  endfunction

  // The stored value wins over the CDB. Tag 0 means the operand is already in the register file.
  function automatic logic [32:0] query(input logic [ROB_ID_W-1:0] t, input entry_t [ROB_SIZE-1:0] e,
                                        input logic cv, input logic [ROB_ID_W-1:0] cq,
                                        input logic [31:0] cval);
    logic [32:0] r;
    r = '0;
    if (t == '0)                               r = {1'b1, 32'd0};
    else if (tag_ok(t) && e[tag_idx(t)].ready) r = {1'b1, e[tag_idx(t)].v};
    else if (cv && (cq == t))                  r = {1'b1, cval};
    return r;
  endfunction

  assign {ready1_to_dsp, V1_to_dsp} = query(Q1_from_dsp, ent_q, cdb_valid, cdb_Q, cdb_V);
  assign {ready2_to_dsp, V2_to_dsp} = query(Q2_from_dsp, ent_q, cdb_valid, cdb_Q, cdb_V);

  assign Q_to_dsp    = ROB_ID_W'(tail_q) + ROB_ID_W'(1);
  assign full_to_dsp = (cnt_q == CNT_W'(ROB_SIZE));

  assign alloc  = ena_from_dsp && !full_to_dsp && !rollback_q;
  assign wb_idx = tag_idx(cdb_Q);
  assign wb     = cdb_valid && !rollback_q && tag_ok(cdb_Q) && ent_q[wb_idx].busy;
  assign commit = !rollback_q && (cnt_q != '0) && ent_q[head_q].ready;

  always_comb begin
    ent_d         = ent_q;
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_d         = cnt_q + CNT_W'(alloc) - CNT_W'(commit);
    commit_flag_d = 1'b0;
    rollback_d    = 1'b0;
    rd_rf_d       = '0;
    q_rf_d        = '0;
    v_rf_d        = '0;
    pc_if_d       = pc_if_q;
    // The writeback checks busy before this edge, so it cannot hit the slot being allocated.
    if (wb) begin
      ent_d[wb_idx].ready = 1'b1;
      ent_d[wb_idx].v     = cdb_V;
      ent_d[wb_idx].mp    = cdb_mispredict;
      ent_d[wb_idx].tpc   = cdb_target_pc;
    end
    if (alloc) begin
      ent_d[tail_q]      = '0;
      ent_d[tail_q].busy = 1'b1;
      ent_d[tail_q].rd   = rd_from_dsp;
      tail_d             = tail_q + IDX_W'(1);
    end
    if (commit) begin
      commit_flag_d       = 1'b1;
      rd_rf_d             = ent_q[head_q].rd;
      q_rf_d              = ROB_ID_W'(head_q) + ROB_ID_W'(1);
      v_rf_d              = ent_q[head_q].v;
      ent_d[head_q].busy  = 1'b0;
      ent_d[head_q].ready = 1'b0;
      head_d              = head_q + IDX_W'(1);
      // Flush on the commit edge so the rollback cycle already sees an empty buffer.
      if (ent_q[head_q].mp) begin
        rollback_d = 1'b1;
        pc_if_d    = ent_q[head_q].tpc;
        ent_d      = '0;
        head_d     = '0;
        tail_d     = '0;
        cnt_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      cnt_q         <= '0;
      commit_flag_q <= 1'b0;
      rollback_q    <= 1'b0;
      rd_rf_q       <= '0;
      q_rf_q        <= '0;
      v_rf_q        <= '0;
      pc_if_q       <= '0;
    end else begin
      ent_q         <= ent_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      commit_flag_q <= commit_flag_d;
      rollback_q    <= rollback_d;
      rd_rf_q       <= rd_rf_d;
      q_rf_q        <= q_rf_d;
      v_rf_q        <= v_rf_d;
      pc_if_q       <= pc_if_d;
    end
  end

  assign commit_flag_to_rf = commit_flag_q;
  assign rd_to_rf          = rd_rf_q;
  assign Q_to_rf           = q_rf_q;
  assign V_to_rf           = v_rf_q;
  assign rollback_flag     = rollback_q;
  assign pc_to_if          = pc_if_q;
endmodule
